// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency synchronous memory port between instruction fetch and data load/store.
// One access at a time; the winner gets registered read data and a one-cycle ack.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int LCW = $clog2(LAT + 1);
  localparam int SCW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state, state_nxt;
  logic [LCW-1:0] lat_cnt;
  logic [SCW-1:0] starve_cnt;
  logic           owner_if, owner_we;
  logic           if_elig, d_elig, grant_if, grant_d, lat_hit;

  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;
  assign lat_hit  = (lat_cnt == LCW'(LAT));

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    if_elig   = if_req & ~if_ack;
    d_elig    = d_req & ~d_ack;
    case (state)
      IDLE: begin
        // Data normally wins; fetch is forced once data has starved it STARVE_MAX times.
        if (if_elig && (!d_elig || starve_cnt == SCW'(STARVE_MAX))) grant_if = 1'b1;
        else if (d_elig)                                           grant_d  = 1'b1;
        if (grant_if || grant_d) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      owner_if   <= 1'b0;
      owner_we   <= 1'b0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state  <= state_nxt;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (grant_if || grant_d) begin
        mem_en   <= 1'b1;
        mem_we   <= grant_d & d_we;
        mem_addr <= grant_if ? if_addr : d_addr;
        if (grant_d) mem_wdata <= d_wdata;
        owner_if <= grant_if;
        owner_we <= grant_d & d_we;
      end
      if (grant_if)
        starve_cnt <= '0;
      else if (grant_d)
        starve_cnt <= !if_req ? '0 :
                      (starve_cnt == SCW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
      if (state == ISSUE) lat_cnt <= LCW'(1);
      if (state == WAIT) begin
        if (lat_hit) begin
          // Stores leave d_rdata holding the last load result.
          if (owner_if)       if_rdata <= mem_rdata;
          else if (!owner_we) d_rdata  <= mem_rdata;
          if_ack <= owner_if;
          d_ack  <= ~owner_if;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected transactions are queued as requests are driven
// and checked against mem_en / ack activity by a negedge monitor.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, LAT = 3, SM = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_ack, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_ack, d_stall;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic          is_if;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            en_cyc;
    int            ack_cyc;
  } txn_t;

  txn_t          issue_q[$];
  txn_t          ack_q[$];
  txn_t          me;
  int            cyc = 0;
  int            n_cmp = 0, n_bad = 0;
  int            c;
  logic [DW-1:0] last_d = '0;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    if (a == 32'h40) return 32'h8C220004;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: data is valid exactly LAT cycles after mem_en, garbage otherwise.
  logic          pv [1:LAT];
  logic [AW-1:0] pa [1:LAT];
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    pv[1] <= mem_en;
    pa[1] <= mem_addr;
    for (int j = 2; j <= LAT; j++) begin
      pv[j] <= pv[j-1];
      pa[j] <= pa[j-1];
    end
  end
  assign mem_rdata = (pv[LAT] === 1'b1) ? memf(pa[LAT]) : 32'hBADBAD00;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic is_if, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input int en_c, input bit want_ack);
    txn_t t;
    t.is_if = is_if; t.we = we; t.addr = a; t.wdata = wd;
    t.en_cyc = en_c; t.ack_cyc = en_c + 1 + LAT;
    if (!is_if && we) t.rdata = last_d;
    else              t.rdata = memf(a);
    if (!is_if && !we) last_d = t.rdata;
    issue_q.push_back(t);
    if (want_ack) ack_q.push_back(t);
  endtask

  task automatic single(input logic is_if, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd);
    int c0;
    c0 = cyc;
    if (is_if) begin
      if_req = 1'b1; if_addr = a;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end
    push(is_if, we, a, wd, c0 + 1, 1'b1);
    @(negedge clk);
    chk(is_if ? "if_stall_req" : "d_stall_req", is_if ? if_stall : d_stall, 1);
    goto(c0 + 3 + LAT);
    if_req = 1'b0;
    d_req  = 1'b0;
    goto(cyc + 1);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("if_stall", if_stall, if_req & ~if_ack);
      chk("d_stall", d_stall, d_req & ~d_ack);
      if (mem_en !== 1'b1) chk("mem_we_idle", mem_we, 0);
      if (mem_en === 1'b1) begin
        chk("mem_en_expected", issue_q.size() != 0, 1);
        if (issue_q.size() != 0) begin
          me = issue_q.pop_front();
          chk("en_cyc", cyc, me.en_cyc);
          chk("mem_addr", mem_addr, me.addr);
          chk("mem_we", mem_we, me.we);
          if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
        end
      end
      if (if_ack === 1'b1 || d_ack === 1'b1) begin
        chk("ack_expected", ack_q.size() != 0, 1);
        chk("ack_onehot", if_ack & d_ack, 0);
        if (ack_q.size() != 0) begin
          me = ack_q.pop_front();
          chk("ack_owner", if_ack, me.is_if);
          chk("ack_cyc", cyc, me.ack_cyc);
          if (me.is_if) chk("if_rdata", if_rdata, me.rdata);
          else          chk("d_rdata", d_rdata, me.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requests held, then both compete on release: data first, then fetch.
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1;
    if_addr = 32'h40; d_addr = 32'h100; d_we = 1'b0; d_wdata = '0;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_if_ack", if_ack, 0);
      chk("rst_d_ack", d_ack, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    c = cyc;
    push(1'b0, 1'b0, 32'h100, '0, c + 1, 1'b1);
    push(1'b1, 1'b0, 32'h40, '0, c + 4 + LAT, 1'b1);
    goto(c + 3 + LAT); d_req = 1'b0;
    goto(c + 6 + 2 * LAT); if_req = 1'b0;
    goto(cyc + 1);

    // Single fetch, a load, then a store that must leave d_rdata alone.
    single(1'b1, 1'b0, 32'h40, '0);
    single(1'b0, 1'b0, 32'h104, '0);
    single(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);

    // Both held continuously: D, D, IF, D, D, IF.
    c = cyc;
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int i = 0; i < 6; i++)
      push(i % 3 == 2, 1'b0, (i % 3 == 2) ? 32'h200 : 32'h300, '0, c + 1 + i * (LAT + 3), 1'b1);
    goto(c + 3 + LAT + 5 * (LAT + 3));
    if_req = 1'b0; d_req = 1'b0;
    goto(cyc + 1);

    // Reset during WAIT: the access is abandoned without an ack.
    c = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    push(1'b0, 1'b0, 32'h400, '0, c + 1, 1'b0);
    goto(c + 3);
    rst_n = 1'b0; d_req = 1'b0;
    goto(c + 5);
    rst_n = 1'b1;
    last_d = '0;
    @(negedge clk);
    chk("mid_rst_d_rdata", d_rdata, 0);
    chk("mid_rst_if_rdata", if_rdata, 0);
    chk("mid_rst_d_ack", d_ack, 0);
    goto(cyc + 1);
    single(1'b0, 1'b0, 32'h500, '0);
    single(1'b1, 1'b0, 32'h44, '0);

    goto(cyc + 5);
    chk("issue_q_left", issue_q.size(), 0);
    chk("ack_q_left", ack_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
